// File: rtl/imem_program_loader.sv
// Byte-stream program loader for instruction memory.
// Frame: N (2 bytes, LSB first), N words (low byte first), XOR checksum.
module imem_program_loader #(
  parameter int DEPTH   = 512,
  parameter int TIMEOUT = 50000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        start,
  input  logic        rx_valid,
  input  logic [7:0]  rx_byte,
  output logic        rx_ready,
  output logic        instr_mem_write_enable,
  output logic [15:0] MachineCodeAddress,
  output logic [15:0] MachineCodeData,
  output logic        cpu_hold,
  output logic        load_done,
  output logic        load_err,
  output logic [15:0] words_loaded
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [3:0] {
    IDLE, LEN_LO, LEN_HI, DATA_LO, DATA_HI,
    WRITE, CHECK, DONE, ERR
  } state_t;

  state_t          state;
  state_t          nxt;
  logic [7:0]      len_lo;
  logic [7:0]      data_lo;
  logic [7:0]      csum;
  logic [15:0]     len;
  logic [15:0]     len_rx;
  logic [TW-1:0]   tmo;
  logic            xfer;
  logic            tmo_hit;

  assign xfer    = rx_valid & rx_ready;
  assign tmo_hit = (tmo == TW'(TIMEOUT - 1));
  assign len_rx  = {rx_byte, len_lo};

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (start) nxt = LEN_LO;
      LEN_LO:  if (xfer) nxt = LEN_HI;
      LEN_HI:
        if (xfer) begin
          if (len_rx == 16'd0)
            nxt = CHECK;
          else if (len_rx > 16'(DEPTH))
            nxt = ERR;
          else
            nxt = DATA_LO;
        end
      DATA_LO: if (xfer) nxt = DATA_HI;
      DATA_HI: if (xfer) nxt = WRITE;
      WRITE:   nxt = (words_loaded < len) ? DATA_LO : CHECK;
      CHECK:
        if (xfer) nxt = (rx_byte == csum) ? DONE : ERR;
      DONE:    nxt = IDLE;
      ERR:     nxt = IDLE;
      default: nxt = IDLE;
    endcase
    // a stalled sender aborts the frame
    if (rx_ready && !xfer && tmo_hit)
      nxt = ERR;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state                  <= IDLE;
      rx_ready               <= 1'b0;
      instr_mem_write_enable <= 1'b0;
      MachineCodeAddress     <= '0;
      MachineCodeData        <= '0;
      cpu_hold               <= 1'b0;
      load_done              <= 1'b0;
      load_err               <= 1'b0;
      words_loaded           <= '0;
      len_lo                 <= '0;
      data_lo                <= '0;
      csum                   <= '0;
      len                    <= '0;
      tmo                    <= '0;
    end else begin
      state <= nxt;
      rx_ready <= nxt inside
        {LEN_LO, LEN_HI, DATA_LO, DATA_HI, CHECK};
      instr_mem_write_enable <= (nxt == WRITE);
      load_done <= (nxt == DONE);
      cpu_hold  <= !(nxt inside {IDLE, DONE, ERR});
      if (nxt == ERR)
        load_err <= 1'b1;
      if (state == IDLE && start) begin
        load_err     <= 1'b0;
        words_loaded <= '0;
        csum         <= '0;
        tmo          <= '0;
      end
      if (rx_ready)
        tmo <= xfer ? '0 : tmo + TW'(1);
      if (xfer) begin
        if (state != CHECK)
          csum <= csum ^ rx_byte;
        unique case (state)
          LEN_LO:  len_lo <= rx_byte;
          LEN_HI:  len <= len_rx;
          DATA_LO: data_lo <= rx_byte;
          DATA_HI: begin
            MachineCodeAddress <= words_loaded;
            MachineCodeData    <= {rx_byte, data_lo};
            words_loaded       <= words_loaded + 16'd1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_program_loader.sv
// Randomized bench for imem_program_loader with a
// byte-index reference model checked every cycle.
module tb_imem_program_loader;

  localparam int TMO = 16;
  localparam int DEP = 512;

  typedef logic [7:0] bq_t[$];

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        start = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_byte = 8'h00;
  logic        rx_ready;
  logic        instr_mem_write_enable;
  logic [15:0] MachineCodeAddress;
  logic [15:0] MachineCodeData;
  logic        cpu_hold;
  logic        load_done;
  logic        load_err;
  logic [15:0] words_loaded;

  imem_program_loader #(.DEPTH(DEP), .TIMEOUT(TMO)) dut (
    .CLK(CLK),
    .RST(RST),
    .start(start),
    .rx_valid(rx_valid),
    .rx_byte(rx_byte),
    .rx_ready(rx_ready),
    .instr_mem_write_enable(instr_mem_write_enable),
    .MachineCodeAddress(MachineCodeAddress),
    .MachineCodeData(MachineCodeData),
    .cpu_hold(cpu_hold),
    .load_done(load_done),
    .load_err(load_err),
    .words_loaded(words_loaded)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;
  int edge_n = 0;
  int done_cnt = 0;
  logic [31:0] wlog[$];

  always @(posedge CLK) edge_n <= edge_n + 1;

  // reference model: expected outputs for the current cycle
  bit          m_idle = 1'b1;
  bit          m_busy = 1'b0;
  int          m_k = 0;
  int          m_n = 0;
  int          m_tmo = 0;
  logic [7:0]  m_ck = 8'h00;
  logic [7:0]  m_lo = 8'h00;
  logic        e_ready = 1'b0;
  logic        e_we = 1'b0;
  logic        e_done = 1'b0;
  logic        e_err = 1'b0;
  logic        e_hold = 1'b0;
  logic [15:0] e_addr = 16'h0;
  logic [15:0] e_data = 16'h0;
  logic [15:0] e_wl = 16'h0;

  task automatic finish_frame(input bit ok);
    m_busy  = 1'b0;
    m_idle  = 1'b0;
    e_ready = 1'b0;
    e_hold  = 1'b0;
    if (ok) e_done = 1'b1;
    else    e_err  = 1'b1;
  endtask

  task automatic model_step();
    logic [7:0] b;
    if (RST) begin
      m_idle = 1'b1; m_busy = 1'b0;
      e_ready = 0; e_we = 0; e_done = 0; e_err = 0; e_hold = 0;
      e_addr = '0; e_data = '0; e_wl = '0;
      return;
    end
    e_we = 1'b0;
    e_done = 1'b0;
    if (!m_busy) begin
      e_hold = 1'b0;
      e_ready = 1'b0;
      if (m_idle && start) begin
        m_busy = 1'b1; m_idle = 1'b0;
        m_k = 0; m_ck = 8'h00; m_tmo = 0;
        e_wl = '0; e_err = 1'b0;
        e_ready = 1'b1; e_hold = 1'b1;
      end else begin
        m_idle = 1'b1;
      end
    end else if (!e_ready) begin
      e_ready = 1'b1;
    end else if (rx_valid) begin
      b = rx_byte;
      m_tmo = 0;
      if (m_k == 0) begin
        m_lo = b; m_ck ^= b;
      end else if (m_k == 1) begin
        m_n = int'({b, m_lo});
        m_ck ^= b;
        if (m_n > DEP) finish_frame(1'b0);
      end else if (m_k < 2 + 2 * m_n) begin
        m_ck ^= b;
        if (m_k % 2 == 0) begin
          m_lo = b;
        end else begin
          e_we = 1'b1;
          e_addr = 16'((m_k - 2) / 2);
          e_data = {b, m_lo};
          e_wl = e_wl + 16'd1;
          e_ready = 1'b0;
        end
      end else begin
        finish_frame(b == m_ck);
      end
      m_k++;
    end else if (m_tmo == TMO - 1) begin
      finish_frame(1'b0);
    end else begin
      m_tmo++;
    end
  endtask

  always @(negedge CLK) begin
    logic [52:0] got, exp;
    got = {rx_ready, instr_mem_write_enable, load_done,
           load_err, cpu_hold, MachineCodeAddress,
           MachineCodeData, words_loaded};
    exp = {e_ready, e_we, e_done, e_err, e_hold,
           e_addr, e_data, e_wl};
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL cycle%0d outputs got=%h exp=%h",
               edge_n, got, exp);
    end
    if (instr_mem_write_enable)
      wlog.push_back({MachineCodeAddress, MachineCodeData});
    if (load_done) done_cnt++;
    model_step();
  end

  task automatic chk(input string nm,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  int last_x_edge = 0;
  int end_edge = 0;

  // result: 1 done, 2 err, 3 reset, 0 budget expired
  task automatic send_frame(input bq_t q,
                            input int maxgap,
                            input int stall_at,
                            input int rst_at,
                            output int res);
    int idx = 0;
    bit x;
    start = 1'b1;
    tick();
    start = 1'b0;
    res = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (idx < q.size() && idx != stall_at &&
          $urandom_range(0, maxgap) == 0) begin
        rx_valid = 1'b1;
        rx_byte  = q[idx];
      end else begin
        rx_valid = 1'b0;
        rx_byte  = 8'($urandom);
      end
      if (cyc == rst_at) rx_valid = 1'b1;
      if (cyc == rst_at) RST = 1'b1;
      @(negedge CLK);
      x = rx_valid && rx_ready;
      if (x) last_x_edge = edge_n + 1;
      if (load_done || load_err) begin
        end_edge = edge_n;
        res = load_done ? 1 : 2;
        tick();
        rx_valid = 1'b0;
        return;
      end
      tick();
      if (RST) begin
        RST = 1'b0;
        rx_valid = 1'b0;
        res = 3;
        return;
      end
      if (x) idx++;
    end
    rx_valid = 1'b0;
  endtask

  function automatic bq_t make_frame(input int n,
                                     input bit good);
    bq_t q;
    logic [7:0] ck = 8'h00;
    q.push_back(8'(n));
    q.push_back(8'(n >> 8));
    for (int i = 0; i < 2 * n && i < 40; i++)
      q.push_back(8'($urandom));
    foreach (q[i]) ck ^= q[i];
    q.push_back(good ? ck : ~ck);
    return q;
  endfunction

  initial begin
    int res;
    int nw;
    bq_t f1;
    bq_t f;
    f1 = '{8'h02, 8'h00, 8'h34, 8'h12, 8'h78, 8'h56, 8'h0A};

    tick();
    tick();
    chk("reset_outputs",
        {rx_ready, instr_mem_write_enable, MachineCodeAddress,
         MachineCodeData, cpu_hold, load_done, load_err,
         words_loaded}, 64'h0);
    RST = 1'b0;
    rx_valid = 1'b1;
    rx_byte = 8'hAA;
    tick();
    tick();
    chk("idle_no_accept", {rx_ready, cpu_hold}, 64'h0);
    rx_valid = 1'b0;

    send_frame(f1, 0, -1, -1, res);
    chk("t1_result", res, 1);
    chk("t1_nwrites", wlog.size(), 2);
    chk("t1_write0", wlog[0], 32'h0000_1234);
    chk("t1_write1", wlog[1], 32'h0001_5678);
    chk("t1_words", words_loaded, 16'd2);
    chk("t1_hold", cpu_hold, 0);
    chk("t1_done_cnt", done_cnt, 1);

    f = f1;
    f[6] = 8'h09;
    send_frame(f, 0, -1, -1, res);
    chk("t2_result", res, 2);
    chk("t2_nwrites", wlog.size(), 4);
    chk("t2_err", load_err, 1);
    chk("t2_no_done", done_cnt, 1);

    f = '{8'h00, 8'h00, 8'h00};
    send_frame(f, 0, -1, -1, res);
    chk("t4_result", res, 1);
    chk("t4_err_cleared", load_err, 0);
    chk("t4_words", words_loaded, 16'd0);
    chk("t4_nwrites", wlog.size(), 4);

    f = '{8'h01, 8'h02, 8'h11, 8'h22, 8'h33};
    send_frame(f, 0, -1, -1, res);
    chk("t3_result", res, 2);
    chk("t3_nwrites", wlog.size(), 4);

    send_frame(f1, 0, 3, -1, res);
    chk("t5_result", res, 2);
    chk("t5_gap", end_edge - last_x_edge, TMO);
    chk("t5_ready", rx_ready, 0);

    nw = wlog.size();
    send_frame(f1, 0, -1, 3, res);
    chk("t6_result", res, 3);
    chk("t6_outputs",
        {rx_ready, instr_mem_write_enable, MachineCodeAddress,
         MachineCodeData, cpu_hold, load_done, load_err,
         words_loaded}, 64'h0);
    tick();
    chk("t6_no_write", wlog.size(), nw);

    for (int i = 0; i < 40; i++) begin
      int n;
      n = ($urandom_range(0, 7) == 0) ?
          int'($urandom_range(DEP + 1, DEP + 90)) :
          int'($urandom_range(0, 5));
      f = make_frame(n, $urandom_range(0, 3) != 0);
      send_frame(f, $urandom_range(0, 3),
                 ($urandom_range(0, 7) == 0) ?
                   int'($urandom_range(0, 8)) : -1,
                 ($urandom_range(0, 9) == 0) ?
                   int'($urandom_range(0, 20)) : -1,
                 res);
      chk("rand_frame_ended", res != 0, 1);
      for (int j = $urandom_range(0, 3); j > 0; j--) begin
        rx_valid = $urandom_range(0, 1);
        rx_byte = 8'($urandom);
        tick();
      end
      rx_valid = 1'b0;
    end

    tick();
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
